// File: rtl/hc166_scan_ctrl.sv
// hc166_scan_ctrl: sequences a chain of 74HC166 PISO registers into a parallel snapshot
module hc166_scan_ctrl #(
    parameter int NUM_DEV = 2,
    parameter int DIV     = 4
) (
    input  logic                 cp,
    input  logic                 mr_n,
    input  logic                 start,
    input  logic                 auto_scan,
    output logic                 busy,
    output logic                 done,
    output logic [8*NUM_DEV-1:0] data,
    output logic                 sr_cp,
    output logic                 sr_pe_n,
    output logic                 sr_ce_n,
    output logic                 sr_mr_n,
    input  logic                 sr_q7
);
    localparam int W  = 8 * NUM_DEV;
    localparam int BW = $clog2(W);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    typedef enum logic [2:0] {IDLE, LOAD_LO, LOAD_HI, SH_LO, SH_HI, DONE} state_t;

    state_t          state, next_state;
    logic [DW-1:0]   div_cnt;
    logic [BW-1:0]   bit_idx;
    logic [W-1:0]    shadow;
    logic            phase_end, timed, last_bit;

    assign phase_end = div_cnt == DIV_LAST;
    assign timed     = state inside {LOAD_LO, LOAD_HI, SH_LO, SH_HI};
    assign last_bit  = bit_idx == BIT_LAST;

    // state register; pins are registered from the next state so they never glitch
    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sr_cp   <= 1'b0;
            sr_pe_n <= 1'b1;
            sr_ce_n <= 1'b1;
        end else begin
            state   <= next_state;
            busy    <= next_state != IDLE;
            done    <= next_state == DONE;
            sr_cp   <= next_state inside {LOAD_HI, SH_HI};
            sr_pe_n <= !(next_state inside {LOAD_LO, LOAD_HI});
            sr_ce_n <= next_state inside {IDLE, DONE};
        end
    end

    // phase sequencing: each timed phase lasts DIV cycles, one sample per low half
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD_LO;
            LOAD_LO: if (phase_end) next_state = LOAD_HI;
            LOAD_HI: if (phase_end) next_state = SH_LO;
            SH_LO:   if (phase_end) next_state = last_bit ? DONE : SH_HI;
            SH_HI:   if (phase_end) next_state = SH_LO;
            DONE:    next_state = auto_scan ? LOAD_LO : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // half-period timer, bit counter, shadow capture and snapshot publish
    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            div_cnt <= '0;
            bit_idx <= '0;
            shadow  <= '0;
            data    <= '0;
        end else begin
            div_cnt <= (timed && !phase_end) ? div_cnt + DW'(1) : '0;
            if (state == LOAD_HI && phase_end)
                bit_idx <= '0;
            else if (state == SH_HI && phase_end)
                bit_idx <= bit_idx + BW'(1);
            if (state == SH_LO && phase_end)
                shadow <= {shadow[W-2:0], sr_q7};
            if (state == SH_LO && phase_end && last_bit)
                data <= {shadow[W-2:0], sr_q7};
        end
    end

    // chain reset is released on the first clock after our own reset lifts
    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n)
            sr_mr_n <= 1'b0;
        else
            sr_mr_n <= 1'b1;
    end
endmodule

// File: tb/tb_hc166_scan_ctrl.sv
// tb_hc166_scan_ctrl: directed and randomized checks of hc166_scan_ctrl against a scan-timeline model
module tb_hc166_scan_ctrl;
    localparam int N   = 2;
    localparam int DIV = 4;
    localparam int W   = 8 * N;
    localparam int L   = 2*DIV + (16*N-1)*DIV + 1;

    logic cp = 0, mr_n = 0, start = 0, auto_scan = 0;
    logic busy, done, sr_cp, sr_pe_n, sr_ce_n, sr_mr_n, sr_q7;
    logic [W-1:0] data;
    logic start_b = 0;
    logic busy_b, done_b, sr_cp_b, sr_pe_n_b, sr_ce_n_b, sr_mr_n_b, sr_q7_b;
    logic [7:0] data_b;

    int checks = 0, fails = 0, cycle = 0;

    always #5 cp = ~cp;

    hc166_scan_ctrl #(.NUM_DEV(N), .DIV(DIV)) dut (
        .cp(cp), .mr_n(mr_n), .start(start), .auto_scan(auto_scan),
        .busy(busy), .done(done), .data(data),
        .sr_cp(sr_cp), .sr_pe_n(sr_pe_n), .sr_ce_n(sr_ce_n), .sr_mr_n(sr_mr_n),
        .sr_q7(sr_q7)
    );

    hc166_scan_ctrl #(.NUM_DEV(1), .DIV(1)) dut_b (
        .cp(cp), .mr_n(mr_n), .start(start_b), .auto_scan(1'b0),
        .busy(busy_b), .done(done_b), .data(data_b),
        .sr_cp(sr_cp_b), .sr_pe_n(sr_pe_n_b), .sr_ce_n(sr_ce_n_b), .sr_mr_n(sr_mr_n_b),
        .sr_q7(sr_q7_b)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cycle);
        end
    endtask

    // HC166 chain: device 0 in the top byte, its Q7 is the chain output, last DS tied low
    logic [7:0] d0 = 0, d1 = 0, d_b = 0;
    logic [W-1:0] chain = '0;
    logic [7:0] chain_b = '0;
    int loads = 0, shifts = 0;
    assign sr_q7   = chain[W-1];
    assign sr_q7_b = chain_b[7];

    always @(posedge sr_cp or negedge sr_mr_n) begin
        if (!sr_mr_n)
            chain <= '0;
        else if (!sr_ce_n) begin
            if (!sr_pe_n) begin
                chain <= {d0, d1};
                loads++;
            end else begin
                chain <= {chain[W-2:0], 1'b0};
                shifts++;
            end
        end
    end

    always @(posedge sr_cp_b or negedge sr_mr_n_b) begin
        if (!sr_mr_n_b)
            chain_b <= '0;
        else if (!sr_ce_n_b)
            chain_b <= !sr_pe_n_b ? d_b : {chain_b[6:0], 1'b0};
    end

    // scan timeline model: position p within a scan determines every output
    logic act = 0, exp_mr = 0, e_cp, e_pe_n, e_ce_n, e_done;
    logic [W-1:0] snap = '0, exp_data = '0;
    int p = 0, base_l = 0, base_s = 0, runlen = 0, lastrun = 0, ndone = 0;

    always @(posedge cp) begin
        cycle++;
        if (!mr_n) begin
            act = 0;
            exp_data = '0;
            exp_mr = 0;
        end else begin
            exp_mr = 1;
            if (!act) begin
                if (start) begin
                    act = 1;
                    p = 0;
                end
            end else if (p == L-1) begin
                if (auto_scan) p = 0;
                else act = 0;
            end else
                p++;
            if (act && p == 0) begin
                base_l = loads;
                base_s = shifts;
            end
            if (act && p == DIV) snap = {d0, d1};
            if (act && p == L-1) exp_data = snap;
        end
        #1;
        e_done = act && p == L-1;
        e_cp   = act && p < L-1 && ((p / DIV) % 2 == 1);
        e_pe_n = !(act && p < 2*DIV);
        e_ce_n = !(act && p < L-1);
        chk("busy", busy, act);
        chk("done", done, e_done);
        chk("sr_cp", sr_cp, e_cp);
        chk("sr_pe_n", sr_pe_n, e_pe_n);
        chk("sr_ce_n", sr_ce_n, e_ce_n);
        chk("sr_mr_n", sr_mr_n, exp_mr);
        chk("data", data, exp_data);
        if (e_done) begin
            chk("load_edges", loads - base_l, 1);
            chk("shift_edges", shifts - base_s, W-1);
        end
        if (done) ndone++;
        if (busy) runlen++;
        else if (runlen > 0) begin
            lastrun = runlen;
            runlen = 0;
        end
    end

    task automatic tick();
        @(negedge cp);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge cp);
        start = 0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!done && n < max) begin
            @(negedge cp);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(negedge cp);
            n++;
        end
        chk("went_idle", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, t1, quiet, blen, rises, bad, bdone;
        logic prev;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", data, 0);
        chk("rst_sr_cp", sr_cp, 0);
        chk("rst_sr_pe_n", sr_pe_n, 1);
        chk("rst_sr_ce_n", sr_ce_n, 1);
        chk("rst_sr_mr_n", sr_mr_n, 0);
        mr_n = 1;
        #1 chk("sr_mr_n_before_edge", sr_mr_n, 0);
        tick();
        chk("sr_mr_n_after_edge", sr_mr_n, 1);
        quiet = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy || sr_cp) quiet++;
        end
        chk("idle_quiet", quiet, 0);

        d0 = 8'hA5;
        d1 = 8'h3C;
        n0 = ndone;
        pulse_start();
        repeat (19) tick();
        pulse_start();
        wait_idle(300);
        tick();
        chk("scan_len", lastrun, 133);
        chk("single_done", ndone - n0, 1);
        chk("data_a53c", data, 16'hA53C);
        repeat (20) tick();
        chk("no_second_scan", ndone - n0, 1);

        auto_scan = 1;
        n0 = ndone;
        pulse_start();
        repeat (30) tick();
        d0 = 8'h5A;
        wait_done(300);
        chk("auto_first", data, 16'hA53C);
        t1 = cycle;
        tick();
        chk("auto_restart_busy", busy, 1);
        auto_scan = 0;
        wait_done(300);
        chk("auto_second", data, 16'h5A3C);
        chk("done_spacing", cycle - t1, 133);
        wait_idle(300);
        chk("auto_done_count", ndone - n0, 2);

        tick();
        n0 = ndone;
        pulse_start();
        repeat (61) tick();
        #2 mr_n = 0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_sr_ce_n", sr_ce_n, 1);
        chk("midrst_sr_cp", sr_cp, 0);
        chk("midrst_data", data, 0);
        chk("midrst_sr_mr_n", sr_mr_n, 0);
        repeat (2) tick();
        mr_n = 1;
        tick();
        chk("midrst_no_done", ndone - n0, 0);
        d0 = 8'h96;
        d1 = 8'h4B;
        pulse_start();
        wait_done(300);
        chk("after_rst_data", data, 16'h964B);
        tick();

        for (int i = 0; i < 4000; i++) begin
            tick();
            start = $urandom_range(0, 29) == 0;
            if ($urandom_range(0, 199) == 0) auto_scan = ~auto_scan;
            if ($urandom_range(0, 49) == 0) d0 = 8'($urandom);
            if ($urandom_range(0, 49) == 0) d1 = 8'($urandom);
            if ($urandom_range(0, 1999) == 0) begin
                mr_n = 0;
                tick();
                mr_n = 1;
            end
        end
        tick();
        start = 0;
        auto_scan = 0;
        wait_idle(400);

        d_b = 8'h81;
        start_b = 1;
        tick();
        start_b = 0;
        blen = 0;
        rises = 0;
        bad = 0;
        bdone = 0;
        prev = 0;
        for (int q = 0; q < 25; q++) begin
            if (busy_b) blen++;
            if (done_b) bdone++;
            if (sr_cp_b !== ((q % 2 == 1) && q < 17)) bad++;
            if (sr_cp_b && !prev) rises++;
            prev = sr_cp_b;
            tick();
        end
        chk("b_scan_len", blen, 18);
        chk("b_cp_pattern", bad, 0);
        chk("b_cp_rises", rises, 8);
        chk("b_done_count", bdone, 1);
        chk("b_data", data_b, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
